wb_retire_unit: RTL and testbench

WB_RETIRE_UNIT -- requirements
Module: wb_retire_unit

---
 rtl/wb_retire_unit_pkg.sv | 34 +++
 rtl/wb_bypass_cam.sv | 26 ++
 rtl/wb_retire_unit.sv | 134 +++++++++++++
 tb/tb_wb_retire_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_unit_pkg.sv
// Shared types for the writeback retire unit: optype encodings, the default
// write-enable mask and the FIFO entry layout.
package wb_retire_unit_pkg;

  localparam int unsigned EntDw = 32;
  localparam int unsigned EntAw = 5;

  // Bit k set means optype k produces a register write.
  localparam logic [63:0] WeMaskDefault = 64'h0000_0000_0008_0077;

  typedef enum logic [5:0] {
    OpAlu    = 6'h00,
    OpAluImm = 6'h01,
    OpLui    = 6'h02,
    OpStore  = 6'h03,
    OpLoad   = 6'h04,
    OpJal    = 6'h05,
    OpJalr   = 6'h06,
    OpBranch = 6'h07,
    OpCsr    = 6'h13
  } optype_e;

  typedef struct packed {
    logic [EntAw-1:0] addr;
    logic [EntDw-1:0] data;
    logic             we;
  } wb_entry_t;

  function automatic logic op_writes_reg(input logic [63:0] mask, input logic [5:0] op,
                                         input logic [EntAw-1:0] addr);
    return mask[op] && (addr != '0);
  endfunction

endpackage

// File: rtl/wb_bypass_cam.sv
// Priority address match for one bypass lookup port; candidate 0 is the youngest.
module wb_bypass_cam
  import wb_retire_unit_pkg::*;
#(
  parameter int unsigned NumEnt = 4
) (
  input  logic                   [EntAw-1:0] addr_i,
  input  wb_entry_t [NumEnt-1:0]             ent_i,
  input  logic      [NumEnt-1:0]             vld_i,
  output logic                               hit_o,
  output logic                   [EntDw-1:0] data_o
);

  // Scan oldest to youngest so the youngest match is the last to assign.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = int'(NumEnt) - 1; i >= 0; i--) begin
      if (vld_i[i] && ent_i[i].we && (addr_i != '0) && (ent_i[i].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_i[i].data;
      end
    end
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback retire unit: 2-entry result FIFO draining into the register file.
// Define WB_RETIRE_BYPASS_EN to build the commit history and bypass lookup ports.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int unsigned DW         = EntDw,
  parameter int unsigned AW         = EntAw,
  parameter int unsigned HIST_DEPTH = 2,
  parameter logic [63:0] WE_MASK    = WeMaskDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] in_regaddr_i,
  input  logic [DW-1:0] in_regdata_i,
  input  logic [5:0]    in_optype_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_addr_o,
  output logic [DW-1:0] rf_data_o,
  input  logic          rf_ready_i,
  input  logic [AW-1:0] byp_addr_a_i,
  input  logic [AW-1:0] byp_addr_b_i,
  output logic          byp_hit_a_o,
  output logic          byp_hit_b_o,
  output logic [DW-1:0] byp_data_a_o,
  output logic [DW-1:0] byp_data_b_o,
  output logic [31:0]   retired_cnt_o
);

  wb_entry_t [1:0] slot_q, slot_d;  // slot 0 is the head
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     retired_cnt_q, retired_cnt_d;
  wb_entry_t       new_ent;
  logic            push, pop, commit, head_vld;

  assign in_ready_o = (cnt_q != 2'd2);
  assign push       = in_valid_i && in_ready_o;
  assign head_vld   = (cnt_q != 2'd0);
  // Non-writing heads retire unconditionally; writing heads wait for the RF.
  assign pop        = head_vld && (!slot_q[0].we || rf_ready_i);
  assign commit     = pop && slot_q[0].we;

  assign rf_we_o   = head_vld && slot_q[0].we;
  assign rf_addr_o = rf_we_o ? slot_q[0].addr : '0;
  assign rf_data_o = rf_we_o ? slot_q[0].data : '0;

  assign retired_cnt_o = retired_cnt_q;

  always_comb begin
    new_ent.addr = in_regaddr_i;
    new_ent.data = in_regdata_i;
    new_ent.we   = op_writes_reg(WE_MASK, in_optype_i, in_regaddr_i);
  end

  always_comb begin
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    retired_cnt_d = retired_cnt_q + 32'(commit);
    if (pop) begin
      slot_d[0] = slot_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      slot_d[cnt_d[0]] = new_ent;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      cnt_q         <= '0;
      retired_cnt_q <= '0;
    end else begin
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

`ifdef WB_RETIRE_BYPASS_EN
  localparam int unsigned NumCand = 2 + HIST_DEPTH;

  wb_entry_t [HIST_DEPTH-1:0] hist_q, hist_d;  // index 0 is the newest commit
  wb_entry_t [NumCand-1:0]    cand;
  logic      [NumCand-1:0]    cand_vld;

  always_comb begin
    hist_d = hist_q;
    if (commit) begin
      for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = slot_q[0];
    end
  end

  // History validity is carried by the we bit, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  assign cand     = {hist_q, slot_q[0], (cnt_q == 2'd2) ? slot_q[1] : slot_q[0]};
  assign cand_vld = {{HIST_DEPTH{1'b1}}, (cnt_q == 2'd2), head_vld};

  wb_bypass_cam #(
    .NumEnt(NumCand)
  ) u_cam_a (
    .addr_i(byp_addr_a_i),
    .ent_i (cand),
    .vld_i (cand_vld),
    .hit_o (byp_hit_a_o),
    .data_o(byp_data_a_o)
  );

  wb_bypass_cam #(
    .NumEnt(NumCand)
  ) u_cam_b (
    .addr_i(byp_addr_b_i),
    .ent_i (cand),
    .vld_i (cand_vld),
    .hit_o (byp_hit_b_o),
    .data_o(byp_data_b_o)
  );
`else
  logic unused_byp;
  assign unused_byp   = ^{byp_addr_a_i, byp_addr_b_i, HIST_DEPTH[0]};
  assign byp_hit_a_o  = 1'b0;
  assign byp_hit_b_o  = 1'b0;
  assign byp_data_a_o = '0;
  assign byp_data_b_o = '0;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Randomized bench for wb_retire_unit against a queue-based reference model.
module tb_wb_retire_unit;

  localparam logic [63:0] Mask = 64'h0000_0000_0008_0077;
  localparam int          Hd   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_regaddr = '0;
  logic [31:0] in_regdata = '0;
  logic [5:0]  in_optype = '0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_ready = 1'b0;
  logic [4:0]  byp_addr_a = '0;
  logic [4:0]  byp_addr_b = '0;
  logic        byp_hit_a, byp_hit_b;
  logic [31:0] byp_data_a, byp_data_b;
  logic [31:0] retired_cnt;

  wb_retire_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_regaddr_i (in_regaddr),
    .in_regdata_i (in_regdata),
    .in_optype_i  (in_optype),
    .rf_we_o      (rf_we),
    .rf_addr_o    (rf_addr),
    .rf_data_o    (rf_data),
    .rf_ready_i   (rf_ready),
    .byp_addr_a_i (byp_addr_a),
    .byp_addr_b_i (byp_addr_b),
    .byp_hit_a_o  (byp_hit_a),
    .byp_hit_b_o  (byp_hit_b),
    .byp_data_a_o (byp_data_a),
    .byp_data_b_o (byp_data_b),
    .retired_cnt_o(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        we;
  } ent_t;

  ent_t        fifo_m[$];
  ent_t        hist_m[$];
  logic [31:0] cnt_m = '0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest FIFO entry first, then committed history newest first.
  function automatic logic [32:0] byp_model(input logic [4:0] a);
`ifdef WB_RETIRE_BYPASS_EN
    if (a == 5'd0) return '0;
    for (int i = fifo_m.size() - 1; i >= 0; i--)
      if (fifo_m[i].we && fifo_m[i].a == a) return {1'b1, fifo_m[i].d};
    for (int i = 0; i < hist_m.size(); i++)
      if (hist_m[i].a == a) return {1'b1, hist_m[i].d};
`endif
    return '0;
  endfunction

  task automatic check_all();
    logic        exp_we;
    logic [32:0] ea, eb;
    exp_we = (fifo_m.size() > 0) && fifo_m[0].we;
    check_eq("in_ready", 32'(in_ready), 32'(fifo_m.size() < 2));
    check_eq("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      check_eq("rf_addr", 32'(rf_addr), 32'(fifo_m[0].a));
      check_eq("rf_data", rf_data, fifo_m[0].d);
    end
    check_eq("retired_cnt", retired_cnt, cnt_m);
    ea = byp_model(byp_addr_a);
    eb = byp_model(byp_addr_b);
    check_eq("byp_hit_a", 32'(byp_hit_a), 32'(ea[32]));
    check_eq("byp_data_a", byp_data_a, ea[31:0]);
    check_eq("byp_hit_b", 32'(byp_hit_b), 32'(eb[32]));
    check_eq("byp_data_b", byp_data_b, eb[31:0]);
  endtask

  task automatic model_tick();
    bit   rdy;
    ent_t e;
    rdy = fifo_m.size() < 2;
    if (fifo_m.size() > 0 && (!fifo_m[0].we || rf_ready)) begin
      e = fifo_m.pop_front();
      if (e.we) begin
        cnt_m++;
        hist_m.push_front(e);
        if (hist_m.size() > Hd) void'(hist_m.pop_back());
      end
    end
    if (in_valid && rdy) begin
      e.a  = in_regaddr;
      e.d  = in_regdata;
      e.we = Mask[in_optype] && (in_regaddr != 5'd0);
      fifo_m.push_back(e);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic [5:0] op, input logic rr, input logic [4:0] ba,
                      input logic [4:0] bb);
    in_valid   = v;
    in_regaddr = a;
    in_regdata = d;
    in_optype  = op;
    rf_ready   = rr;
    byp_addr_a = ba;
    byp_addr_b = bb;
    #1;
    check_all();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  logic [5:0] ops[10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h13, 6'h3f};

  initial begin
    // Reset state.
    #2;
    check_eq("reset_rf_we", 32'(rf_we), 32'd0);
    check_eq("reset_rf_addr", 32'(rf_addr), 32'd0);
    check_eq("reset_rf_data", rf_data, 32'd0);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_byp_hit", 32'({byp_hit_a, byp_hit_b}), 32'd0);
    check_eq("reset_cnt", retired_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, then write appears one cycle after accept.
    step(1'b1, 5'd5, 32'h1234_5678, 6'h00, 1'b1, 5'd0, 5'd0);
    check_eq("req036_rf_data", rf_data, 32'h1234_5678);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd5, 5'd0);
    check_eq("req036_cnt", retired_cnt, 32'd1);

    // Non-writing optype and address-zero write.
    step(1'b1, 5'd7, 32'hdead_beef, 6'h03, 1'b0, 5'd7, 5'd0);
    step(1'b1, 5'd0, 32'h0bad_0bad, 6'h00, 1'b0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b0, 5'd0, 5'd0);
    check_eq("req037_cnt", retired_cnt, 32'd1);

    // Backpressure: fill, stall, then drain in order.
    step(1'b1, 5'd1, 32'h11, 6'h00, 1'b0, 5'd1, 5'd2);
    step(1'b1, 5'd2, 32'h22, 6'h01, 1'b0, 5'd1, 5'd2);
    step(1'b1, 5'd3, 32'h33, 6'h02, 1'b0, 5'd3, 5'd2);
    check_eq("req038_full", 32'(in_ready), 32'd0);
    step(1'b1, 5'd3, 32'h33, 6'h02, 1'b0, 5'd3, 5'd1);
    step(1'b1, 5'd3, 32'h33, 6'h02, 1'b1, 5'd3, 5'd1);
    step(1'b1, 5'd3, 32'h33, 6'h02, 1'b1, 5'd3, 5'd2);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd3, 5'd2);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd3, 5'd1);

    // Pending write shadows a committed one at the same address.
    step(1'b1, 5'd9, 32'hA, 6'h00, 1'b1, 5'd9, 5'd0);
    step(1'b1, 5'd9, 32'hB, 6'h00, 1'b1, 5'd9, 5'd0);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b0, 5'd9, 5'd0);
`ifdef WB_RETIRE_BYPASS_EN
    check_eq("req039_hit", 32'({byp_hit_a, byp_hit_b}), 32'b10);
    check_eq("req039_data", byp_data_a, 32'hB);
`endif
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd9, 5'd0);

    // Counter wrap.
    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    step(1'b1, 5'd4, 32'h44, 6'h04, 1'b1, 5'd4, 5'd0);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd4, 5'd0);
    check_eq("req040_wrap", retired_cnt, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
           ops[$urandom_range(0, 9)], ($urandom_range(0, 9) < 6),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Reset with two pending writes.
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd6, 32'h66, 6'h00, 1'b0, 5'd6, 5'd0);
    step(1'b1, 5'd8, 32'h88, 6'h00, 1'b0, 5'd6, 5'd8);
    check_eq("req040_pending", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    fifo_m.delete();
    hist_m.delete();
    cnt_m = '0;
    #1;
    check_eq("rst_mid_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step(1'b0, 5'd0, 32'h0, 6'h00, 1'b1, 5'd6, 5'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
